elevator_call_scheduler: RTL and testbench

- Collects floor call requests into a pending-call register and picks the next target floor with a LOOK policy: keep serving calls in the current direction, reverse only when none remain ahead.
- Sits between the button inputs and the elevator motion state machine.
- Drives that state machine's requested floor, and reads back its current floor and a stopped indication.
- Also sequences a timed door-open phase after each arrival.

---
 rtl/elevator_call_scheduler.sv | 275 +++++++++++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_call_scheduler
//
// Collects floor calls into a pending bitmap and hands the motion state machine
// its next target floor using a LOOK sweep: keep serving calls in the current
// direction and reverse only when nothing remains ahead. After each arrival a
// timed door-open phase runs before the next move is requested.
//
// Ports:
//   i_clk            clock, all logic on the rising edge
//   i_rst            synchronous reset, active-high
//   i_req_valid      one-cycle call strobe
//   i_req_floor      floor of the call, sampled with i_req_valid
//   i_current_floor  floor reported by the motion state machine
//   i_car_stopped    1 = motion state machine idle (car not moving)
//   o_target_floor   registered requested floor for the motion state machine
//   o_pending        registered pending-call bitmap, bit i = call at floor i
//   o_dir_up         current sweep direction, 1 = up
//   o_door_open      1 during the door phase
//   o_busy           1 whenever the scheduler is not IDLE
//   o_req_err        one-cycle pulse when a call is rejected (floor out of range)
//
// Build option:
//   IDLE_HOME_EN     when defined, an idle car away from floor 0 is sent home
//                    (target 0, direction down) after HOME_TIMEOUT quiet cycles.
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no move requested; waits for a pending call
// MOVE  | target_floor tracks the LOOK choice until the car arrives
// DOOR  | door held open for DOOR_TICKS cycles, then IDLE or next MOVE
// -----------------------------------------------------------------------------
module elevator_call_scheduler #(
  parameter int          NUM_FLOORS   = 10,
  parameter logic [31:0] DOOR_TICKS   = 32'd100000,
  parameter logic [31:0] HOME_TIMEOUT = 32'd1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  input  logic [3:0]            i_req_floor,
  input  logic [3:0]            i_current_floor,
  input  logic                  i_car_stopped,
  output logic [3:0]            o_target_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_dir_up,
  output logic                  o_door_open,
  output logic                  o_busy,
  output logic                  o_req_err
);

  // Elaboration-time parameter sanity checks.
  if (NUM_FLOORS < 1 || NUM_FLOORS > 16) begin : g_bad_num_floors
    $error("elevator_call_scheduler: NUM_FLOORS must be 1..16");
  end
  if (DOOR_TICKS == 32'd0 || HOME_TIMEOUT == 32'd0) begin : g_bad_ticks
    $error("elevator_call_scheduler: DOOR_TICKS and HOME_TIMEOUT must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [3:0]            r_target_floor;
  logic                  r_dir_up;
  logic                  r_door_open;
  logic                  r_busy;
  logic                  r_req_err;
  logic [31:0]           r_door_cnt;
`ifdef IDLE_HOME_EN
  logic [31:0]           r_idle_cnt;
`endif

  // One-hot views of the request, the car position and the current target.
  // Floors outside 0..NUM_FLOORS-1 simply produce an all-zero mask.
  logic [NUM_FLOORS-1:0] w_req_mask;
  logic [NUM_FLOORS-1:0] w_cur_mask;
  logic [NUM_FLOORS-1:0] w_tgt_mask;

  always_comb begin
    w_req_mask = '0;
    w_cur_mask = '0;
    w_tgt_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_req_mask[i] = i_req_valid && (i_req_floor == 4'(i));
      w_cur_mask[i] = (i_current_floor == 4'(i));
      w_tgt_mask[i] = (r_target_floor == 4'(i));
    end
  end

  // Nearest pending call strictly above / strictly below the car.
  logic       w_up_found;
  logic [3:0] w_up_floor;
  logic       w_dn_found;
  logic [3:0] w_dn_floor;

  always_comb begin
    w_up_found = 1'b0;
    w_up_floor = 4'd0;
    w_dn_found = 1'b0;
    w_dn_floor = 4'd0;
    // Scanning downward leaves the lowest hit above the car.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (4'(i) > i_current_floor)) begin
        w_up_found = 1'b1;
        w_up_floor = 4'(i);
      end
    end
    // Scanning upward leaves the highest hit below the car.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i] && (4'(i) < i_current_floor)) begin
        w_dn_found = 1'b1;
        w_dn_floor = 4'(i);
      end
    end
  end

  logic       w_any_pend;
  logic       w_pend_here;
  logic [3:0] w_hold_floor;
  logic       w_dir_new;
  logic [3:0] w_tgt_new;
  logic [3:0] w_tgt_keep;
  logic       w_arrive;
  logic       w_absorb;
  logic       w_req_err;
  logic       w_door_tc;

  assign w_any_pend  = |r_pending;
  assign w_pend_here = |(r_pending & w_cur_mask);

  // With nothing pending in the chosen direction the only sensible target is
  // a call at the car itself; failing that the previous target is kept, which
  // always lies inside the valid floor range.
  assign w_hold_floor = w_pend_here ? i_current_floor : r_target_floor;

  // Direction decision on entry to MOVE: keep sweeping while calls remain
  // ahead, otherwise reverse. The target below follows the new direction.
  assign w_dir_new = r_dir_up ? w_up_found : ~w_dn_found;

  assign w_tgt_new  = w_dir_new ? (w_up_found ? w_up_floor : w_hold_floor)
                                : (w_dn_found ? w_dn_floor : w_hold_floor);

  assign w_tgt_keep = r_dir_up  ? (w_up_found ? w_up_floor : w_hold_floor)
                                : (w_dn_found ? w_dn_floor : w_hold_floor);

  assign w_arrive = i_car_stopped && (i_current_floor == r_target_floor) &&
                    |(r_pending & w_tgt_mask);

  // A call for the floor whose door is already open needs no service; it
  // just keeps the door open longer.
  assign w_absorb  = (r_state == ST_DOOR) && |(w_req_mask & w_cur_mask);

  // An in-range strobe always lights exactly one mask bit.
  assign w_req_err = i_req_valid && !(|w_req_mask);

  assign w_door_tc = (r_door_cnt == DOOR_TICKS - 32'd1);

  // Bits set by new calls and bits cleared by service in the same cycle;
  // the clear is applied last so a same-floor call at arrival is dropped.
  logic [NUM_FLOORS-1:0] w_set_mask;
  logic [NUM_FLOORS-1:0] w_clr_mask;

  always_comb begin
    w_set_mask = w_absorb ? '0 : w_req_mask;
    w_clr_mask = '0;
    if (r_state == ST_IDLE && w_pend_here && i_car_stopped) begin
      w_clr_mask = w_cur_mask;
    end else if (r_state == ST_MOVE && w_arrive) begin
      w_clr_mask = w_tgt_mask;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_pending      <= '0;
      r_target_floor <= 4'd0;
      r_dir_up       <= 1'b1;
      r_door_open    <= 1'b0;
      r_busy         <= 1'b0;
      r_req_err      <= 1'b0;
      r_door_cnt     <= 32'd0;
`ifdef IDLE_HOME_EN
      r_idle_cnt     <= 32'd0;
`endif
    end else begin
      r_req_err <= w_req_err;
      r_pending <= (r_pending | w_set_mask) & ~w_clr_mask;

      case (r_state)
        ST_IDLE: begin
          if (w_any_pend) begin
            if (w_pend_here && i_car_stopped) begin
              r_state     <= ST_DOOR;
              r_busy      <= 1'b1;
              r_door_open <= 1'b1;
              r_door_cnt  <= 32'd0;
            end else begin
              r_state        <= ST_MOVE;
              r_busy         <= 1'b1;
              r_dir_up       <= w_dir_new;
              r_target_floor <= w_tgt_new;
            end
          end
        end

        ST_MOVE: begin
          if (w_arrive) begin
            r_state     <= ST_DOOR;
            r_door_open <= 1'b1;
            r_door_cnt  <= 32'd0;
          end else begin
            r_target_floor <= w_tgt_keep;
          end
        end

        ST_DOOR: begin
          if (w_absorb) begin
            r_door_cnt <= 32'd0;
          end else if (w_door_tc) begin
            r_door_cnt  <= 32'd0;
            r_door_open <= 1'b0;
            if (!w_any_pend) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state        <= ST_MOVE;
              r_dir_up       <= w_dir_new;
              r_target_floor <= w_tgt_new;
            end
          end else begin
            r_door_cnt <= r_door_cnt + 32'd1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_door_open <= 1'b0;
          r_door_cnt  <= 32'd0;
        end
      endcase

`ifdef IDLE_HOME_EN
      // Quiet-car timer; only IDLE with nothing pending leaves target/dir
      // untouched in the case above, so homing never collides with it.
      if (r_state == ST_IDLE && !w_any_pend && i_car_stopped &&
          !i_req_valid && i_current_floor != 4'd0) begin
        if (r_idle_cnt == HOME_TIMEOUT - 32'd1) begin
          r_idle_cnt     <= 32'd0;
          r_target_floor <= 4'd0;
          r_dir_up       <= 1'b0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 32'd1;
        end
      end else begin
        r_idle_cnt <= 32'd0;
      end
`endif
    end
  end

  assign o_target_floor = r_target_floor;
  assign o_pending      = r_pending;
  assign o_dir_up       = r_dir_up;
  assign o_door_open    = r_door_open;
  assign o_busy         = r_busy;
  assign o_req_err      = r_req_err;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
module tb_elevator_call_scheduler;

  localparam int NF = 10;
  localparam int DT = 8;
  localparam int HT = 20;

  localparam int S_IDLE = 0;
  localparam int S_MOVE = 1;
  localparam int S_DOOR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [3:0]    req_floor = 4'd0;
  logic [3:0]    current_floor = 4'd0;
  logic          car_stopped = 1'b1;
  logic [3:0]    o_target_floor;
  logic [NF-1:0] o_pending;
  logic          o_dir_up;
  logic          o_door_open;
  logic          o_busy;
  logic          o_req_err;

  elevator_call_scheduler #(
    .NUM_FLOORS  (NF),
    .DOOR_TICKS  (32'd8),
    .HOME_TIMEOUT(32'd20)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_floor    (req_floor),
    .i_current_floor(current_floor),
    .i_car_stopped  (car_stopped),
    .o_target_floor (o_target_floor),
    .o_pending      (o_pending),
    .o_dir_up       (o_dir_up),
    .o_door_open    (o_door_open),
    .o_busy         (o_busy),
    .o_req_err      (o_req_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (set of calls + sweep rules) ----------
  bit m_call[NF];
  int m_state = S_IDLE;
  int m_tgt   = 0;
  int m_cnt   = 0;
  int m_idle  = 0;
  bit m_dir   = 1'b1;
  bit m_door  = 1'b0;
  bit m_err   = 1'b0;

  function automatic bit any_call();
    bit a = 1'b0;
    for (int i = 0; i < NF; i++) a |= m_call[i];
    return a;
  endfunction

  function automatic int call_above(int f);
    int r = -1;
    for (int i = f + 1; i < NF; i++) if (m_call[i] && r < 0) r = i;
    return r;
  endfunction

  function automatic int call_below(int f);
    int r = -1;
    for (int i = f - 1; i >= 0; i--) if (m_call[i] && r < 0) r = i;
    return r;
  endfunction

  function automatic int pick(bit up, int f);
    int n = up ? call_above(f) : call_below(f);
    if (n >= 0) return n;
    if (m_call[f]) return f;
    return m_tgt;
  endfunction

  function automatic bit decide(int f);
    if (m_dir) return call_above(f) >= 0;
    return !(call_below(f) >= 0);
  endfunction

  function automatic logic [NF-1:0] m_pend_vec();
    logic [NF-1:0] v = '0;
    for (int i = 0; i < NF; i++) v[i] = m_call[i];
    return v;
  endfunction

  task automatic model_step(input bit rs, input bit rv, input int rf, input int cur, input bit stp);
    int clr;
    bit was_door;
    if (rs) begin
      for (int i = 0; i < NF; i++) m_call[i] = 1'b0;
      m_state = S_IDLE; m_tgt = 0; m_dir = 1'b1; m_door = 1'b0;
      m_err = 1'b0; m_cnt = 0; m_idle = 0;
    end else begin
      clr      = -1;
      was_door = (m_state == S_DOOR);
      m_err    = rv && (rf >= NF);
`ifdef IDLE_HOME_EN
      if (m_state == S_IDLE && !any_call() && stp && !rv && cur != 0) begin
        if (m_idle == HT - 1) begin
          m_idle = 0; m_tgt = 0; m_dir = 1'b0;
        end else m_idle++;
      end else m_idle = 0;
`endif
      case (m_state)
        S_IDLE: if (any_call()) begin
          if (m_call[cur] && stp) begin
            clr = cur; m_state = S_DOOR; m_door = 1'b1; m_cnt = 0;
          end else begin
            m_dir = decide(cur); m_tgt = pick(m_dir, cur); m_state = S_MOVE;
          end
        end
        S_MOVE: begin
          if (stp && cur == m_tgt && m_call[m_tgt]) begin
            clr = m_tgt; m_state = S_DOOR; m_door = 1'b1; m_cnt = 0;
          end else m_tgt = pick(m_dir, cur);
        end
        default: begin
          if (rv && rf == cur) m_cnt = 0;
          else if (m_cnt == DT - 1) begin
            m_cnt = 0; m_door = 1'b0;
            if (!any_call()) m_state = S_IDLE;
            else begin
              m_dir = decide(cur); m_tgt = pick(m_dir, cur); m_state = S_MOVE;
            end
          end else m_cnt++;
        end
      endcase
      if (rv && rf < NF && !(was_door && rf == cur)) m_call[rf] = 1'b1;
      if (clr >= 0) m_call[clr] = 1'b0;
    end
  endtask

  // ---------------- car plant: one floor per 3 cycles toward model target --
  int car    = 0;
  bit car_st = 1'b1;
  int mv_cnt = 0;

  task automatic plant();
    if (m_state == S_MOVE && car != m_tgt) begin
      car_st = 1'b0;
      mv_cnt++;
      if (mv_cnt == 3) begin
        mv_cnt = 0;
        car = (m_tgt > car) ? car + 1 : car - 1;
        if (car == m_tgt) car_st = 1'b1;
      end
    end else begin
      car_st = 1'b1;
      mv_cnt = 0;
    end
  endtask

  task automatic step(input bit rs, input bit rv, input int rf);
    @(negedge clk);
    plant();
    rst           = rs;
    req_valid     = rv;
    req_floor     = 4'(rf);
    current_floor = 4'(car);
    car_stopped   = car_st;
    model_step(rs, rv, rf, car, car_st);
    @(posedge clk);
    #1;
    check_eq("target", 32'(o_target_floor), 32'(m_tgt));
    check_eq("pending", 32'(o_pending), 32'(m_pend_vec()));
    check_eq("dir_up", 32'(o_dir_up), 32'(m_dir));
    check_eq("door_open", 32'(o_door_open), 32'(m_door));
    check_eq("busy", 32'(o_busy), 32'(m_state != S_IDLE));
    check_eq("req_err", 32'(o_req_err), 32'(m_err));
  endtask

  task automatic wait_door_open();
    for (int k = 0; k < 300 && !o_door_open; k++) step(1'b0, 1'b0, 0);
    check_eq("door_seen", 32'(o_door_open), 32'd1);
  endtask

  task automatic count_door(output int len);
    len = 0;
    for (int k = 0; k < 300 && o_door_open; k++) begin
      len++;
      step(1'b0, 1'b0, 0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 600 && !(m_state == S_IDLE && !any_call()); k++) step(1'b0, 1'b0, 0);
    check_eq("drain_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  len;
  bit  r_v;
  bit  r_s;
  int  r_f;

  initial begin
    // Reset then idle
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    check_eq("rst_target", 32'(o_target_floor), 32'd0);
    check_eq("rst_pending", 32'(o_pending), 32'd0);
    check_eq("rst_dir", 32'(o_dir_up), 32'd1);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_door", 32'(o_door_open), 32'd0);

    // Single call from floor 0 to floor 5
    step(1'b0, 1'b1, 5);
    check_eq("single_pend", 32'(o_pending), 32'h020);
    step(1'b0, 1'b0, 0);
    check_eq("single_busy", 32'(o_busy), 32'd1);
    check_eq("single_tgt", 32'(o_target_floor), 32'd5);
    wait_door_open();
    check_eq("single_clr", 32'(o_pending), 32'd0);
    count_door(len);
    check_eq("door_len", 32'(len), 32'(DT));
    check_eq("single_idle", 32'(o_busy), 32'd0);

    // Pick-up on the way: 1 -> 7, call for 4 while at floor 2
    step(1'b0, 1'b1, 1);
    drain();
    step(1'b0, 1'b1, 7);
    for (int k = 0; k < 200 && car != 2; k++) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 4);
    step(1'b0, 1'b0, 0);
    check_eq("pickup_tgt", 32'(o_target_floor), 32'd4);
    wait_door_open();
    count_door(len);
    check_eq("pickup_next", 32'(o_target_floor), 32'd7);
    check_eq("pickup_dir", 32'(o_dir_up), 32'd1);
    drain();

    // LOOK reversal: at 6 heading up with calls {8,2}
    step(1'b0, 1'b1, 0);
    drain();
    step(1'b0, 1'b1, 6);
    wait_door_open();
    step(1'b0, 1'b1, 8);
    step(1'b0, 1'b1, 2);
    count_door(len);
    check_eq("look_tgt8", 32'(o_target_floor), 32'd8);
    check_eq("look_dir_up", 32'(o_dir_up), 32'd1);
    wait_door_open();
    check_eq("look_keep2", 32'(o_pending), 32'h004);
    count_door(len);
    check_eq("look_rev_dir", 32'(o_dir_up), 32'd0);
    check_eq("look_tgt2", 32'(o_target_floor), 32'd2);
    drain();

    // Invalid call, then a call absorbed while the door is open
    step(1'b0, 1'b1, 12);
    check_eq("inv_err", 32'(o_req_err), 32'd1);
    check_eq("inv_pend", 32'(o_pending), 32'd0);
    step(1'b0, 1'b0, 0);
    check_eq("inv_err_clr", 32'(o_req_err), 32'd0);
    step(1'b0, 1'b1, car);
    wait_door_open();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, car);
    check_eq("absorb_pend", 32'(o_pending), 32'd0);
    count_door(len);
    check_eq("absorb_len", 32'(len), 32'(DT));
    drain();

    // Reset in the middle of a move with calls {3,9}
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 9);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    check_eq("mid_rst_pend", 32'(o_pending), 32'd0);
    check_eq("mid_rst_tgt", 32'(o_target_floor), 32'd0);
    check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
    step(1'b0, 1'b0, 0);

`ifdef IDLE_HOME_EN
    // Homing after HOME_TIMEOUT quiet cycles at floor 4
    step(1'b0, 1'b1, 4);
    wait_door_open();
    count_door(len);
    for (int k = 0; k < HT - 1; k++) step(1'b0, 1'b0, 0);
    check_eq("home_wait", 32'(o_target_floor), 32'd4);
    step(1'b0, 1'b0, 0);
    check_eq("home_tgt", 32'(o_target_floor), 32'd0);
    check_eq("home_dir", 32'(o_dir_up), 32'd0);
`endif

    // Randomized traffic, including out-of-range floors and rare resets
    for (int k = 0; k < 2500; k++) begin
      r_v = ($urandom_range(0, 5) == 0);
      r_f = int'($urandom_range(0, 15));
      r_s = ($urandom_range(0, 599) == 0);
      step(r_s, r_v, r_f);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
